axi_rd_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXI4 read master port (AR + R channels) between S_COUNT read requesters.
- Sits upstream of the read width adapter, so several DMA/engine read clients can share one adapter and memory port.
- Tags each granted burst's ID with the requester index in the upper ID bits, and routes R beats back by that tag.
- Limits outstanding bursts per requester.

---
 rtl/axi_rd_arb_pkg.sv | 15 +
 rtl/axi_rd_arbiter_rr_core.sv | 44 ++++
 rtl/axi_rd_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared definitions for the AXI read arbiter slice.
//   arb_state_t : AR channel state (ARB_IDLE, ARB_HOLD)
//   BURST_INCR  : AXI incrementing burst encoding
//   RESP_OKAY   : AXI OKAY response encoding
package axi_rd_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_rd_arbiter_rr_core.sv
// Combinational round-robin pick.
//   req         : request vector, one bit per requester
//   last_grant  : index granted most recently
//   grant_oh    : one-hot grant (all zero when nothing requests)
//   grant_idx   : encoded grant
//   grant_valid : some requester was picked
// Priority starts at last_grant+1 and wraps modulo S_COUNT.
module rr_arbiter_core #(
   parameter int S_COUNT   = 2,
   parameter int SEL_WIDTH = 1
) (
   input  logic [S_COUNT-1:0]   req,
   input  logic [SEL_WIDTH-1:0] last_grant,
   output logic [S_COUNT-1:0]   grant_oh,
   output logic [SEL_WIDTH-1:0] grant_idx,
   output logic                 grant_valid
);

   // Two descending passes: the lowest wrapped-around candidate is found first,
   // then any candidate above last_grant overrides it, since it comes earlier
   // in round-robin order.
   always_comb begin
      grant_oh    = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int i = S_COUNT-1; i >= 0; i--) begin
         if (req[i] && i <= int'(last_grant)) begin
            grant_oh    = '0;
            grant_oh[i] = 1'b1;
            grant_idx   = SEL_WIDTH'(i);
            grant_valid = 1'b1;
         end
      end
      for (int i = S_COUNT-1; i >= 0; i--) begin
         if (req[i] && i > int'(last_grant)) begin
            grant_oh    = '0;
            grant_oh[i] = 1'b1;
            grant_idx   = SEL_WIDTH'(i);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master (AR + R) among S_COUNT
// requesters. The granted requester index is placed in the upper ARID bits,
// and R beats are routed back by those bits. Bursts in flight are limited per requester.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   s_axi_ar*              : flattened requester AR channels (port 0 in LSBs)
//   s_axi_r*               : flattened requester R channels (payload broadcast)
//   m_axi_ar*, m_axi_r*    : shared master AR / R channels
//   stat_grant_count       : per-requester 16-bit grant counters, present only
//                            when AXI_RD_ARB_STATS_EN is defined
//
// state    | meaning
// ARB_IDLE | arbitrating; s_axi_arready pulses for the picked requester
// ARB_HOLD | m_axi_arvalid high with stable fields until m_axi_arready
module axi_rd_arbiter
   import axi_rd_arb_pkg::*;
#(
   parameter int S_COUNT         = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int ID_WIDTH        = 8,
   parameter int MAX_OUTSTANDING = 4,
   localparam int SEL_WIDTH      = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
   localparam int M_ID_WIDTH     = ID_WIDTH + SEL_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [S_COUNT*ID_WIDTH-1:0]     s_axi_arid,
   input  logic [S_COUNT*ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [S_COUNT*8-1:0]            s_axi_arlen,
   input  logic [S_COUNT*3-1:0]            s_axi_arsize,
   input  logic [S_COUNT*2-1:0]            s_axi_arburst,
   input  logic [S_COUNT-1:0]              s_axi_arvalid,
   output logic [S_COUNT-1:0]              s_axi_arready,
   output logic [S_COUNT*ID_WIDTH-1:0]     s_axi_rid,
   output logic [S_COUNT*DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [S_COUNT*2-1:0]            s_axi_rresp,
   output logic [S_COUNT-1:0]              s_axi_rlast,
   output logic [S_COUNT-1:0]              s_axi_rvalid,
   input  logic [S_COUNT-1:0]              s_axi_rready,
   output logic [M_ID_WIDTH-1:0]           m_axi_arid,
   output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
   output logic [7:0]                      m_axi_arlen,
   output logic [2:0]                      m_axi_arsize,
   output logic [1:0]                      m_axi_arburst,
   output logic                            m_axi_arvalid,
   input  logic                            m_axi_arready,
   input  logic [M_ID_WIDTH-1:0]           m_axi_rid,
   input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
   input  logic [1:0]                      m_axi_rresp,
   input  logic                            m_axi_rlast,
   input  logic                            m_axi_rvalid,
   output logic                            m_axi_rready
`ifdef AXI_RD_ARB_STATS_EN
   ,
   output logic [S_COUNT*16-1:0]           stat_grant_count
`endif
);

   arb_state_t           state;
   logic [SEL_WIDTH-1:0] last_grant;
   logic [3:0]           cnt [S_COUNT];
   logic [S_COUNT-1:0]   eligible;
   logic [S_COUNT-1:0]   grant_oh;
   logic [SEL_WIDTH-1:0] grant_idx;
   logic                 grant_valid;
   logic [S_COUNT-1:0]   ar_take;
   logic [S_COUNT-1:0]   r_done;
   logic [SEL_WIDTH-1:0] r_sel;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         eligible[i] = s_axi_arvalid[i] && (cnt[i] < 4'(MAX_OUTSTANDING));
      end
   end

   rr_arbiter_core #(
      .S_COUNT   (S_COUNT),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_rr_core (
      .req         (eligible),
      .last_grant  (last_grant),
      .grant_oh    (grant_oh),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // The grant is the AR handshake itself, so arready is driven combinationally
   // from the registered state; gating with rst keeps it low during reset.
   assign ar_take       = (state == ARB_IDLE && !rst) ? grant_oh : '0;
   assign s_axi_arready = ar_take;
   assign m_axi_arvalid = (state == ARB_HOLD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ARB_IDLE;
         last_grant    <= SEL_WIDTH'(S_COUNT-1);
         m_axi_arid    <= '0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= '0;
         m_axi_arsize  <= '0;
         m_axi_arburst <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant_valid) begin
                  for (int i = 0; i < S_COUNT; i++) begin
                     if (grant_oh[i]) begin
                        m_axi_arid    <= {SEL_WIDTH'(i), s_axi_arid[i*ID_WIDTH +: ID_WIDTH]};
                        m_axi_araddr  <= s_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        m_axi_arlen   <= s_axi_arlen[i*8 +: 8];
                        m_axi_arsize  <= s_axi_arsize[i*3 +: 3];
                        m_axi_arburst <= s_axi_arburst[i*2 +: 2];
                     end
                  end
                  last_grant <= grant_idx;
                  state      <= ARB_HOLD;
               end
            end
            ARB_HOLD: begin
               if (m_axi_arready) state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Eligibility stops granting at MAX_OUTSTANDING, so no overflow guard.
   always_ff @(posedge clk) begin
      for (int i = 0; i < S_COUNT; i++) begin
         if (rst) begin
            cnt[i] <= '0;
         end else if (ar_take[i] && !r_done[i]) begin
            cnt[i] <= cnt[i] + 4'd1;
         end else if (!ar_take[i] && r_done[i]) begin
            cnt[i] <= cnt[i] - 4'd1;
         end
      end
   end

   assign r_sel = m_axi_rid[M_ID_WIDTH-1 -: SEL_WIDTH];

   // A tag with no matching requester leaves rready at 1 so the beat drains.
   always_comb begin
      s_axi_rvalid = '0;
      r_done       = '0;
      m_axi_rready = 1'b1;
      for (int i = 0; i < S_COUNT; i++) begin
         if (r_sel == SEL_WIDTH'(i)) begin
            s_axi_rvalid[i] = m_axi_rvalid;
            m_axi_rready    = s_axi_rready[i];
            r_done[i]       = m_axi_rvalid && s_axi_rready[i] && m_axi_rlast;
         end
      end
   end

   assign s_axi_rid   = {S_COUNT{m_axi_rid[ID_WIDTH-1:0]}};
   assign s_axi_rdata = {S_COUNT{m_axi_rdata}};
   assign s_axi_rresp = {S_COUNT{m_axi_rresp}};
   assign s_axi_rlast = {S_COUNT{m_axi_rlast}};

`ifdef AXI_RD_ARB_STATS_EN
   logic [15:0] grant_cnt [S_COUNT];

   always_ff @(posedge clk) begin
      for (int i = 0; i < S_COUNT; i++) begin
         if (rst) begin
            grant_cnt[i] <= '0;
         end else if (ar_take[i]) begin
            grant_cnt[i] <= grant_cnt[i] + 16'd1;
         end
      end
   end

   always_comb begin
      stat_grant_count = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         stat_grant_count[i*16 +: 16] = grant_cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter (S_COUNT=2, MAX_OUTSTANDING=4). Expected master AR
// transfers and requester R beats are queued when stimulus is issued; monitor
// threads pop and compare on every handshake. Cycle-level grant patterns are
// checked directly against hand-written sequences.
module tb_axi_rd_arbiter;
   import axi_rd_arb_pkg::*;

   localparam int S_COUNT = 2;
   localparam int MIDW    = 9;

   typedef struct packed {
      logic [8:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } ar_exp_t;

   typedef struct packed {
      logic [3:0]  port;
      logic [7:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [S_COUNT*8-1:0]  s_axi_arid;
   logic [S_COUNT*32-1:0] s_axi_araddr;
   logic [S_COUNT*8-1:0]  s_axi_arlen;
   logic [S_COUNT*3-1:0]  s_axi_arsize;
   logic [S_COUNT*2-1:0]  s_axi_arburst;
   logic [S_COUNT-1:0]    s_axi_arvalid;
   logic [S_COUNT-1:0]    s_axi_arready;
   logic [S_COUNT*8-1:0]  s_axi_rid;
   logic [S_COUNT*32-1:0] s_axi_rdata;
   logic [S_COUNT*2-1:0]  s_axi_rresp;
   logic [S_COUNT-1:0]    s_axi_rlast;
   logic [S_COUNT-1:0]    s_axi_rvalid;
   logic [S_COUNT-1:0]    s_axi_rready;
   logic [MIDW-1:0]       m_axi_arid;
   logic [31:0]           m_axi_araddr;
   logic [7:0]            m_axi_arlen;
   logic [2:0]            m_axi_arsize;
   logic [1:0]            m_axi_arburst;
   logic                  m_axi_arvalid;
   logic                  m_axi_arready;
   logic [MIDW-1:0]       m_axi_rid;
   logic [31:0]           m_axi_rdata;
   logic [1:0]            m_axi_rresp;
   logic                  m_axi_rlast;
   logic                  m_axi_rvalid;
   logic                  m_axi_rready;
`ifdef AXI_RD_ARB_STATS_EN
   logic [S_COUNT*16-1:0] stat_grant_count;
`endif

   int vectors;
   int miscompares;
   ar_exp_t ar_q[$];
   r_exp_t  r_q[$];

   always #5 clk = ~clk;

   axi_rd_arbiter #(
      .S_COUNT(S_COUNT), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .MAX_OUTSTANDING(4)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef AXI_RD_ARB_STATS_EN
      , .stat_grant_count(stat_grant_count)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ar(input int p, input logic [7:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
      s_axi_arid[p*8 +: 8]     = id;
      s_axi_araddr[p*32 +: 32] = addr;
      s_axi_arlen[p*8 +: 8]    = len;
      s_axi_arsize[p*3 +: 3]   = 3'd2;
      s_axi_arburst[p*2 +: 2]  = BURST_INCR;
   endtask

   task automatic push_ar(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len);
      ar_exp_t e;
      e.id = id; e.addr = addr; e.len = len;
      ar_q.push_back(e);
   endtask

   // Drives one master R beat; when expect_port >= 0 the routed beat is queued.
   task automatic drive_r(input logic [8:0] rid, input logic [31:0] data, input logic [1:0] resp,
                          input logic last, input int expect_port);
      r_exp_t e;
      m_axi_rvalid = 1'b1;
      m_axi_rid    = rid;
      m_axi_rdata  = data;
      m_axi_rresp  = resp;
      m_axi_rlast  = last;
      if (expect_port >= 0) begin
         e.port = 4'(expect_port); e.id = rid[7:0]; e.data = data; e.resp = resp; e.last = last;
         r_q.push_back(e);
      end
   endtask

   task automatic monitor_ar();
      ar_exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && m_axi_arvalid && m_axi_arready) begin
            if (ar_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL ar_unexpected: got arid %0h, expected no transfer", m_axi_arid);
            end else begin
               e = ar_q.pop_front();
               check("ar_transfer",
                     {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst},
                     {e.id, e.addr, e.len, 3'd2, BURST_INCR});
            end
         end
      end
   endtask

   task automatic monitor_r();
      r_exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int i = 0; i < S_COUNT; i++) begin
               if (s_axi_rvalid[i] && s_axi_rready[i]) begin
                  if (r_q.size() == 0) begin
                     vectors++; miscompares++;
                     $display("FAIL r_unexpected: got beat on port %0d, expected none", i);
                  end else begin
                     e = r_q.pop_front();
                     check("r_beat",
                           {4'(i), s_axi_rid[i*8 +: 8], s_axi_rdata[i*32 +: 32],
                            s_axi_rresp[i*2 +: 2], s_axi_rlast[i]},
                           {e.port, e.id, e.data, e.resp, e.last});
                  end
               end
            end
         end
      end
   endtask

   initial begin
      logic [1:0] seq_c [8];
      logic [1:0] seq_l [10];
      logic [1:0] seq_p1 [6];
      logic [1:0] seq_rs [4];
      logic       rr1;
      int         b;
      int         k;

      vectors = 0; miscompares = 0;
      rst = 1'b1;
      s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
      s_axi_arburst = '0; s_axi_arvalid = 2'b11; s_axi_rready = '0;
      m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = RESP_OKAY;
      m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
      fork
         monitor_ar();
         monitor_r();
      join_none

      // Reset state, with requests present to show arready stays low.
      repeat (2) step();
      @(negedge clk);
      check("reset_arready", s_axi_arready, 2'b00);
      check("reset_arvalid", m_axi_arvalid, 1'b0);
      check("reset_araddr", m_axi_araddr, 32'h0);
      check("reset_arid", m_axi_arid, 9'h0);
      s_axi_arvalid = 2'b00;
      step();
      rst = 1'b0;

      // Single request from port 1, held until the master accepts.
      set_ar(1, 8'h05, 32'h0000_1000, 8'd3);
      s_axi_arvalid = 2'b10;
      push_ar(9'h105, 32'h0000_1000, 8'd3);
      @(negedge clk);
      check("single_arready", s_axi_arready, 2'b10);
      step();
      s_axi_arvalid = 2'b00;
      @(negedge clk);
      check("single_arvalid", m_axi_arvalid, 1'b1);
      check("single_arid", m_axi_arid, 9'h105);
      check("single_araddr", m_axi_araddr, 32'h0000_1000);
      check("hold_arready", s_axi_arready, 2'b00);
      step();
      @(negedge clk);
      check("hold_arid_stable", m_axi_arid, 9'h105);
      check("hold_arvalid", m_axi_arvalid, 1'b1);
      step();
      m_axi_arready = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      check("single_arvalid_drop", m_axi_arvalid, 1'b0);
      step();

      // Contention: alternation 0,1,0,1 at one grant per two cycles.
      set_ar(0, 8'h11, 32'h0000_2000, 8'd0);
      set_ar(1, 8'h22, 32'h0000_3000, 8'd3);
      s_axi_arvalid = 2'b11;
      push_ar(9'h011, 32'h0000_2000, 8'd0);
      push_ar(9'h122, 32'h0000_3000, 8'd3);
      push_ar(9'h011, 32'h0000_2000, 8'd0);
      push_ar(9'h122, 32'h0000_3000, 8'd3);
      seq_c = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("contend_arready", s_axi_arready, seq_c[i]);
         step();
         if (i == 6) s_axi_arvalid = 2'b00;
      end

      // Port 0 at 2 outstanding: grant coincides with its rlast handshake,
      // then continuous requests must stall at 4 until another rlast.
      set_ar(0, 8'h33, 32'h0000_4000, 8'd0);
      s_axi_arvalid = 2'b01;
      s_axi_rready  = 2'b01;
      drive_r(9'h011, 32'hAAAA_0001, RESP_OKAY, 1'b1, 0);
      for (int i = 0; i < 4; i++) push_ar(9'h033, 32'h0000_4000, 8'd0);
      seq_l = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("limit_arready", s_axi_arready, seq_l[i]);
         if (i == 0) begin
            check("simul_rvalid", s_axi_rvalid, 2'b01);
            check("simul_rready", m_axi_rready, 1'b1);
         end
         step();
         if (i == 0) m_axi_rvalid = 1'b0;
         if (i == 6) drive_r(9'h044, 32'hAAAA_0002, 2'b10, 1'b0, 0);
         if (i == 7) drive_r(9'h044, 32'hAAAA_0003, RESP_OKAY, 1'b1, 0);
         if (i == 8) m_axi_rvalid = 1'b0;
         if (i == 9) s_axi_arvalid = 2'b00;
      end

      // R routing to port 1 with toggling rready; port 0 always ready.
      b = 0;
      k = 0;
      while (b < 4 && k < 16) begin
         rr1 = (k % 2 == 0);
         s_axi_rready = {rr1, 1'b1};
         drive_r(9'h13A, 32'hB000_0000 | 32'(b), RESP_OKAY, (b == 3), rr1 ? 1 : -1);
         @(negedge clk);
         check("route_rvalid", s_axi_rvalid, 2'b10);
         check("route_rready", m_axi_rready, rr1);
         check("route_rid_bcast", s_axi_rid, 16'h3A3A);
         step();
         if (rr1) b++;
         k++;
      end
      check("route_beats", b, 4);
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;

      // Port 1 dropped from 3 to 2 outstanding: exactly two more grants.
      s_axi_arvalid = 2'b10;
      push_ar(9'h122, 32'h0000_3000, 8'd3);
      push_ar(9'h122, 32'h0000_3000, 8'd3);
      seq_p1 = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("p1_limit_arready", s_axi_arready, seq_p1[i]);
         step();
      end
      s_axi_arvalid = 2'b00;

      // Free one port 0 slot, park an AR in HOLD, then reset.
      s_axi_rready = 2'b01;
      drive_r(9'h000, 32'hCCCC_0001, RESP_OKAY, 1'b1, 0);
      @(negedge clk);
      check("pre_rst_rvalid", s_axi_rvalid, 2'b01);
      step();
      m_axi_rvalid  = 1'b0;
      m_axi_arready = 1'b0;
      set_ar(0, 8'h55, 32'h0000_5000, 8'd1);
      s_axi_arvalid = 2'b01;
      @(negedge clk);
      check("pre_rst_arready", s_axi_arready, 2'b01);
      step();
      s_axi_arvalid = 2'b00;
      @(negedge clk);
      check("pre_rst_hold", m_axi_arvalid, 1'b1);
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      check("rst_hold_arvalid", m_axi_arvalid, 1'b0);
      check("rst_hold_araddr", m_axi_araddr, 32'h0);
      check("rst_hold_arready", s_axi_arready, 2'b00);
      step();
      rst = 1'b0;

      // After reset port 0 wins first, and port 1 (was at 4) is eligible again.
      m_axi_arready = 1'b1;
      set_ar(0, 8'h66, 32'h0000_6000, 8'd0);
      set_ar(1, 8'h77, 32'h0000_7000, 8'd2);
      s_axi_arvalid = 2'b11;
      push_ar(9'h066, 32'h0000_6000, 8'd0);
      push_ar(9'h177, 32'h0000_7000, 8'd2);
      seq_rs = '{2'b01, 2'b00, 2'b10, 2'b00};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_arready", s_axi_arready, seq_rs[i]);
         step();
         if (i == 2) s_axi_arvalid = 2'b00;
      end

      repeat (3) step();
      check("ar_queue_empty", 64'(ar_q.size()), 64'd0);
      check("r_queue_empty", 64'(r_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
